nmcu_main_mem: RTL and testbench

Synthesizable main-memory model that sits directly downstream of the NMCU memory-request path. It consumes nmcu_pkg::mem_req_t and produces nmcu_pkg::mem_resp_t. It services single-word writes and multi-word read bursts after a fixed access latency. It is the backing store for the cache, DMA and PE-array loader, both in TB simulation and in FPGA bring-up.

---
 rtl/nmcu_main_mem.sv | 154 +++++++++++++++
 tb/tb_nmcu_main_mem.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/nmcu_main_mem.sv
// Main-memory model behind the NMCU request path: single-word writes and
// multi-word read bursts returned after a fixed access latency.
package nmcu_pkg;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned LEN_W  = 8;

   typedef struct packed {
      logic              valid;
      logic              write_en;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [LEN_W-1:0]  len;
   } mem_req_t;

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] rdata;
      logic              hit;
   } mem_resp_t;
endpackage

module nmcu_main_mem
   import nmcu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = DATA_W,
   parameter int unsigned ADDR_WIDTH     = ADDR_W,
   parameter int unsigned LEN_WIDTH      = LEN_W,
   parameter int unsigned MEM_SIZE_WORDS = 65536,
   parameter int unsigned MEM_LATENCY    = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  mem_req_t   req_i,
   output logic       req_ready_o,
   output mem_resp_t  resp_o,
   input  logic       resp_ready_i,
   output logic       busy_o,
   output logic [1:0] dbg_state_o
);

   // Handshakes: a request is taken on a rising edge with req_i.valid && req_ready_o;
   // a response beat completes on a rising edge with resp_o.valid && resp_ready_i.
   localparam int unsigned IDX_W   = $clog2(MEM_SIZE_WORDS);
   localparam int unsigned LAT_EFF = (MEM_LATENCY == 0) ? 1 : MEM_LATENCY;
   localparam int unsigned LAT_W   = $clog2(LAT_EFF) + 1;
   localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(LAT_EFF - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LAT  = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LEN_WIDTH-1:0]  beats_q, beats_d;
   logic [LAT_W-1:0]      lat_q, lat_d;

   logic [DATA_WIDTH-1:0] mem_q [MEM_SIZE_WORDS];

   logic                  accept;
   logic [IDX_W-1:0]      req_idx;
   logic [ADDR_WIDTH-1:0] req_base;
   logic [LEN_WIDTH-1:0]  req_beats;
   logic                  unused_addr_lsbs;

   assign accept           = req_i.valid && (state_q == ST_IDLE);
   assign req_idx          = req_i.addr[IDX_W+1:2];
   assign req_base         = {req_i.addr[ADDR_WIDTH-1:2], 2'b00};
   assign unused_addr_lsbs = ^req_i.addr[1:0];
   // Writes are always a single beat; a zero-length read still returns one beat.
   assign req_beats = (req_i.write_en || (req_i.len == '0)) ? LEN_WIDTH'(1) : req_i.len;

   // Storage is deliberately not reset so committed data survives an abort.
   always_ff @(posedge clk) begin
      if (accept && req_i.write_en) begin
         mem_q[req_idx] <= req_i.wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         addr_q  <= '0;
         beats_q <= '0;
         lat_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         beats_q <= beats_d;
         lat_q   <= lat_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      addr_d  = addr_q;
      beats_d = beats_q;
      lat_d   = lat_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               idx_d   = req_idx;
               addr_d  = req_base;
               beats_d = req_beats;
               lat_d   = LAT_INIT;
               state_d = ST_LAT;
            end
         end
         ST_LAT: begin
            if (lat_q == '0) begin
               state_d = ST_RESP;
            end else begin
               lat_d = lat_q - LAT_W'(1);
            end
         end
         ST_RESP: begin
            if (resp_ready_i) begin
               if (beats_q == LEN_WIDTH'(1)) begin
                  state_d = ST_IDLE;
               end else begin
                  // Word index wraps naturally at the power-of-two depth.
                  beats_d = beats_q - LEN_WIDTH'(1);
                  idx_d   = idx_q + IDX_W'(1);
                  addr_d  = addr_q + ADDR_WIDTH'(4);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Data is read at presentation time, so a stalled beat stays stable.
   always_comb begin
      resp_o = '0;
      if (state_q == ST_RESP) begin
         resp_o.valid = 1'b1;
         resp_o.addr  = addr_q;
         resp_o.rdata = mem_q[idx_q];
         resp_o.hit   = 1'b0;
      end
   end

   assign req_ready_o = (state_q == ST_IDLE);
   assign busy_o      = (state_q != ST_IDLE);
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_nmcu_main_mem.sv
// Scoreboard bench for nmcu_main_mem: a word-array reference model predicts
// every response beat and first-beat timing; a monitor checks what appears.
module tb_nmcu_main_mem;
   import nmcu_pkg::*;

   localparam int MEM_WORDS = 256;
   localparam int LAT       = 5;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   mem_req_t   req_i = '0;
   logic       req_ready_o;
   mem_resp_t  resp_o;
   logic       resp_ready_i = 1'b1;
   logic       busy_o;
   logic [1:0] dbg_state_o;

   nmcu_main_mem #(
      .MEM_SIZE_WORDS(MEM_WORDS),
      .MEM_LATENCY   (LAT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_i       (req_i),
      .req_ready_o (req_ready_o),
      .resp_o      (resp_o),
      .resp_ready_i(resp_ready_i),
      .busy_o      (busy_o),
      .dbg_state_o (dbg_state_o)
   );

   // ---------------- clock / reset
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state
   logic [63:0] exp_q[$];
   int          lat_q[$];
   logic [31:0] ref_mem [MEM_WORDS];
   int          n_chk = 0;
   int          n_pass = 0;
   logic        rand_ready = 1'b0;
   logic        ready_fixed = 1'b1;
   logic        prev_valid = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- ready driver
   always @(posedge clk) begin
      #1;
      resp_ready_i = rand_ready ? ($urandom_range(0, 3) != 0) : ready_fixed;
   end

   // ---------------- monitor
   always @(negedge clk) begin
      logic [63:0] e;
      if (rst_n) begin
         if (resp_o.valid && !prev_valid) begin
            if (lat_q.size() == 0) check("unexpected_first_beat", 64'(resp_o.valid), 64'd0);
            else check("first_beat_latency", 64'(cyc), 64'(lat_q.pop_front()));
         end
         if (resp_o.valid) begin
            check("hit", 64'(resp_o.hit), 64'd0);
            if (exp_q.size() == 0) begin
               check("extra_beat", 64'(resp_o.valid), 64'd0);
            end else if (resp_ready_i) begin
               e = exp_q.pop_front();
               check("beat_addr_data", {resp_o.addr, resp_o.rdata}, e);
            end else begin
               check("stall_hold", {resp_o.addr, resp_o.rdata}, exp_q[0]);
            end
         end
      end
      prev_valid = rst_n && resp_o.valid;
   end

   // ---------------- driver tasks
   task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic [7:0] len);
      int budget = 0;
      int n;
      logic [31:0] base;
      @(negedge clk);
      while (!req_ready_o && budget < 2000) begin
         @(negedge clk);
         budget++;
      end
      if (!req_ready_o) begin
         check("req_ready_timeout", 64'(req_ready_o), 64'd1);
         return;
      end
      req_i.valid    = 1'b1;
      req_i.write_en = we;
      req_i.addr     = a;
      req_i.wdata    = d;
      req_i.len      = len;
      @(posedge clk);
      #1;
      req_i.valid = 1'b0;
      base = {a[31:2], 2'b00};
      if (we) begin
         ref_mem[(a >> 2) % MEM_WORDS] = d;
         exp_q.push_back({base, d});
      end else begin
         n = (len == 0) ? 1 : int'(len);
         for (int k = 0; k < n; k++)
            exp_q.push_back({base + 32'(4 * k), ref_mem[((a >> 2) + k) % MEM_WORDS]});
      end
      lat_q.push_back(cyc + LAT);
   endtask

   task automatic wait_idle(input string name);
      int budget = 0;
      @(negedge clk);
      while ((busy_o || exp_q.size() != 0) && budget < 3000) begin
         @(negedge clk);
         budget++;
      end
      check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
      check({name, "_not_busy"}, 64'(busy_o), 64'd0);
   endtask

   task automatic wait_valid(input string name);
      int budget = 0;
      while (!resp_o.valid && budget < 50) begin
         @(negedge clk);
         budget++;
      end
      check({name, "_valid_seen"}, 64'(resp_o.valid), 64'd1);
   endtask

   // ---------------- stimulus
   initial begin
      repeat (3) @(negedge clk);
      check("reset_req_ready", 64'(req_ready_o), 64'd1);
      check("reset_resp_valid", 64'(resp_o.valid), 64'd0);
      check("reset_resp_fields", {resp_o.addr, resp_o.rdata}, 64'd0);
      check("reset_busy", 64'(busy_o), 64'd0);
      rst_n = 1'b1;

      for (int i = 0; i < MEM_WORDS; i++) issue(1'b1, 32'(i * 4), $urandom, 8'd0);
      wait_idle("preload");

      issue(1'b1, 32'h100, 32'hDEADBEEF, 8'd3);
      issue(1'b0, 32'h100, 32'h0, 8'd1);
      wait_idle("write_read");

      for (int i = 0; i < 4; i++) issue(1'b1, 32'h40 + 32'(4 * i), 32'(i + 1), 8'd0);
      wait_idle("burst_preload");
      issue(1'b0, 32'h40, 32'h0, 8'd4);
      @(negedge clk);
      wait_valid("burst");
      ready_fixed = 1'b0;
      repeat (3) @(posedge clk);
      ready_fixed = 1'b1;
      wait_idle("burst_stall");

      issue(1'b0, 32'h200, 32'h0, 8'd0);
      wait_idle("len_zero");
      issue(1'b0, 32'h103, 32'h0, 8'd1);
      wait_idle("unaligned");
      issue(1'b0, 32'(4 * (MEM_WORDS - 1)), 32'h0, 8'd2);
      wait_idle("wrap");

      issue(1'b0, 32'h80, 32'h0, 8'd3);
      check("busy_in_lat", 64'(busy_o), 64'd1);
      check("not_ready_in_lat", 64'(req_ready_o), 64'd0);
      @(negedge clk);
      req_i.valid    = 1'b1;
      req_i.write_en = 1'b1;
      req_i.addr     = 32'h84;
      req_i.wdata    = ~ref_mem[33];
      req_i.len      = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      req_i.valid = 1'b0;
      wait_idle("ignored_req");
      issue(1'b0, 32'h84, 32'h0, 8'd1);
      wait_idle("ignored_req_readback");

      issue(1'b0, 32'h40, 32'h0, 8'd4);
      @(negedge clk);
      wait_valid("abort");
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_valid_drop", 64'(resp_o.valid), 64'd0);
      check("abort_busy", 64'(busy_o), 64'd0);
      check("abort_ready", 64'(req_ready_o), 64'd1);
      exp_q.delete();
      lat_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      issue(1'b0, 32'h40, 32'h0, 8'd4);
      wait_idle("after_abort");

      rand_ready = 1'b1;
      for (int i = 0; i < 60; i++) begin
         issue($urandom_range(0, 2) == 0, $urandom, $urandom,
               (i == 30) ? 8'd255 : 8'($urandom_range(0, 6)));
      end
      wait_idle("random");
      rand_ready = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
